// File: rtl/ysyx_210238_mtimer_if.sv
// Single-outstanding valid/ready MMIO port between the core and the machine timer.
// The master issues one request and waits for its response before the next.
interface ysyx_210238_mtimer_if;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic        req_wen;
  logic [63:0] req_wdata;
  logic [7:0]  req_wstrb;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_addr, req_wen, req_wdata, req_wstrb, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_addr, req_wen, req_wdata, req_wstrb, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/ysyx_210238_mtimer.sv
// Machine timer: 64-bit mtime with prescaler, mtimecmp, and a registered level
// interrupt (mtime >= mtimecmp), accessed through a single-outstanding MMIO slave.
module ysyx_210238_mtimer #(
  parameter logic [63:0] BASE_ADDR = 64'h0000_0000_0200_0000,
  parameter int          TICK_DIV  = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  ysyx_210238_mtimer_if.slave         bus,
  output logic                        o_timer_int
);

  localparam int              PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]   PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [63:0]     CMP_ADDR  = BASE_ADDR + 64'h4000;
  localparam logic [63:0]     TIME_ADDR = BASE_ADDR + 64'hBFF8;

  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;

  state_t        state_reg, state_next;
  logic [PW-1:0] presc_reg, presc_next;
  logic [63:0]   mtime_reg, mtime_next, mtime_inc;
  logic [63:0]   mtimecmp_reg, mtimecmp_next;
  logic          timer_int_reg, timer_int_next;
  logic          resp_valid_reg, resp_valid_next;
  logic          resp_err_reg, resp_err_next;
  logic [63:0]   resp_rdata_reg, resp_rdata_next;
  logic          req_ready;
  logic          tick, acc, sel_cmp, sel_time, wr_cmp, wr_time;

  assign tick       = (presc_reg == PRESC_MAX);
  assign presc_next = tick ? '0 : presc_reg + PW'(1);
  assign mtime_inc  = mtime_reg + {63'd0, tick};

  assign sel_cmp  = (bus.req_addr == CMP_ADDR);
  assign sel_time = (bus.req_addr == TIME_ADDR);
  assign acc      = (state_reg == IDLE) && bus.req_valid;
  assign wr_cmp   = acc && bus.req_wen && sel_cmp;
  assign wr_time  = acc && bus.req_wen && sel_time;

  // Byte merge; for mtime the unwritten bytes carry this edge's increment.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_byte
      assign mtime_next[8*gi +: 8]    = (wr_time && bus.req_wstrb[gi]) ?
                                        bus.req_wdata[8*gi +: 8] : mtime_inc[8*gi +: 8];
      assign mtimecmp_next[8*gi +: 8] = (wr_cmp && bus.req_wstrb[gi]) ?
                                        bus.req_wdata[8*gi +: 8] : mtimecmp_reg[8*gi +: 8];
    end
  endgenerate

  assign timer_int_next = (mtime_next >= mtimecmp_next);

  always_comb begin
    state_next      = state_reg;
    resp_valid_next = resp_valid_reg;
    resp_err_next   = resp_err_reg;
    resp_rdata_next = resp_rdata_reg;
    req_ready       = 1'b0;
    case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        if (bus.req_valid) begin
          state_next      = RESP;
          resp_valid_next = 1'b1;
          resp_err_next   = !(sel_cmp || sel_time);
          // Reads see the pre-update register value.
          if (!bus.req_wen && sel_cmp)       resp_rdata_next = mtimecmp_reg;
          else if (!bus.req_wen && sel_time) resp_rdata_next = mtime_reg;
          else                               resp_rdata_next = 64'd0;
        end
      end
      RESP: begin
        if (bus.resp_ready) begin
          state_next      = IDLE;
          resp_valid_next = 1'b0;
          resp_err_next   = 1'b0;
          resp_rdata_next = 64'd0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      presc_reg      <= '0;
      mtime_reg      <= 64'd0;
      mtimecmp_reg   <= 64'hFFFF_FFFF_FFFF_FFFF;
      timer_int_reg  <= 1'b0;
      resp_valid_reg <= 1'b0;
      resp_err_reg   <= 1'b0;
      resp_rdata_reg <= 64'd0;
    end else begin
      state_reg      <= state_next;
      presc_reg      <= presc_next;
      mtime_reg      <= mtime_next;
      mtimecmp_reg   <= mtimecmp_next;
      timer_int_reg  <= timer_int_next;
      resp_valid_reg <= resp_valid_next;
      resp_err_reg   <= resp_err_next;
      resp_rdata_reg <= resp_rdata_next;
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.resp_valid = resp_valid_reg;
  assign bus.resp_err   = resp_err_reg;
  assign bus.resp_rdata = resp_rdata_reg;
  assign o_timer_int    = timer_int_reg;

endmodule

// File: doc/ysyx_210238_mtimer.md
Name: ysyx_210238_mtimer

Overview:
Memory-mapped machine timer peripheral. It holds the 64-bit mtime counter and the mtimecmp register, and generates the registered timer interrupt line that feeds the core's trap controller (its i_timer_int input). Software reads and writes both registers through a single-outstanding valid/ready slave port driven by the core's MMIO path.

Parameters:
BASE_ADDR, 64'h0000_0000_0200_0000, base of the timer region
TICK_DIV, 1, clk cycles per mtime increment (>=1)

Ports:
clk  input  1  clock
rst_n  input  1  reset; asynchronous, active-low
i_req_valid  input  1  request valid
o_req_ready  output  1  request accepted when high together with i_req_valid
i_req_addr  input  64  byte address, 8-byte aligned
i_req_wen  input  1  1 = write, 0 = read
i_req_wdata  input  64  write data
i_req_wstrb  input  8  byte write strobes
o_resp_valid  output  1  response valid
i_resp_ready  input  1  response consumed
o_resp_rdata  output  64  read data (0 for writes and errors)
o_resp_err  output  1  address not decoded
o_timer_int  output  1  machine timer interrupt request, level

Behaviour:
- Reset (asynchronous assert, synchronous-safe release). Outputs and registers take these values:
  - mtime = 0
  - mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF
  - prescale counter = 0
  - o_timer_int = 0
  - o_resp_valid = 0, o_resp_rdata = 0, o_resp_err = 0
  - state = IDLE
- Reset asserted mid-transaction drops any pending response; no partial write survives.
- Register map:
  - BASE_ADDR+0x4000: mtimecmp
  - BASE_ADDR+0xBFF8: mtime
  - Any other address: error.
- Prescaler:
  - The counter counts 0..TICK_DIV-1.
  - tick = 1 in the cycle where the counter equals TICK_DIV-1, and the counter then wraps to 0.
  - mtime increments by 1 on tick and wraps modulo 2^64 (all-ones -> 0).
- Slave FSM:
  - IDLE: o_req_ready = 1. On i_req_valid, perform the access at this clock edge, register the response, go to RESP.
  - RESP: o_req_ready = 0, o_resp_valid = 1, response fields held stable. When i_resp_ready is high, return to IDLE at the next edge and clear the response fields to 0.
  - Minimum request-to-response latency: 1 cycle. Maximum throughput: 1 access per 2 cycles.
- Reads return the register value before this edge's update (pre-tick, pre-write).
- Writes: merge bytes under i_req_wstrb. wstrb = 0 is a legal no-op that still gets a response.
- Error access (unmapped address): o_resp_err = 1, rdata = 0, no register changes.
- Simultaneous software write to mtime and tick: the written bytes take the write data. Unwritten bytes take the incremented value (merge applied to mtime+1).
- Prescaler is unaffected by writes.
- o_timer_int is registered each cycle as (mtime >= mtimecmp), unsigned, using the post-update values of this edge.
  - Result: it rises in the same edge that mtime reaches mtimecmp and is visible 1 cycle after that edge. It falls 1 edge after a write raises mtimecmp above mtime.
  - Level only; no internal pending latch. Clearing it is software's job (write mtimecmp).

Test Plan:
- Reset, no access, TICK_DIV=1 -> mtime reads 0 then advances 1/cycle; mtimecmp reads all-ones; o_timer_int = 0.
- Write mtimecmp = 20 with wstrb = 8'hFF at mtime ≈ 5 -> o_timer_int rises on the edge mtime becomes 20 and stays high; then write mtimecmp = 1000 -> o_timer_int low next cycle.
- TICK_DIV=4 -> mtime increments every 4th cycle; a write of mtime = 7 coinciding with a tick reads back 7; with wstrb = 8'h01 and old mtime 0x100, the result is 0x107.
- Write mtime = 64'hFFFF_FFFF_FFFF_FFFE, mtimecmp = 0 -> o_timer_int high; after 2 ticks mtime wraps to 0 and o_timer_int stays high (0 >= 0).
- Read BASE_ADDR+0x10 -> o_resp_err = 1, rdata = 0, no state change. Hold i_resp_ready low for 5 cycles -> response stable and o_req_ready = 0 throughout.
- Assert rst_n low while in RESP -> o_resp_valid drops immediately (asynchronously); all registers return to reset values.
